// File: rtl/neuron_accum_pkg.sv
// neuron_accum_pkg: shared widths, FSM state codes and helpers for the neuron accumulator.
package neuron_accum_pkg;
   localparam int DATA_W = 16;
   localparam int ACC_W = 32;
   localparam int N_IN = 8;
   localparam int LEAKY_SHIFT = 3;
   localparam int CNT_W = $clog2(N_IN + 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, BIAS = 2'd2, ACT = 2'd3} state_t;
   function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
      return {{(ACC_W - DATA_W){v[DATA_W-1]}}, v};
   endfunction
endpackage

// File: rtl/neuron_accum_if.sv
// neuron_accum_if: partial-sum input stream, activation output stream and status of the accumulator.
interface neuron_accum_if;
   import neuron_accum_pkg::*;
   logic in_valid;
   logic in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic in_last;
   logic signed [DATA_W-1:0] bias;
   logic [4:0] cfg_shift;
   logic out_valid;
   logic out_ready;
   logic signed [DATA_W-1:0] out_data;
   logic ovf;
   logic ovf_clr;
   logic busy;
   modport master (
      output in_valid, in_data, in_last, bias, cfg_shift, out_ready, ovf_clr,
      input in_ready, out_valid, out_data, ovf, busy
   );
   modport slave (
      input in_valid, in_data, in_last, bias, cfg_shift, out_ready, ovf_clr,
      output in_ready, out_valid, out_data, ovf, busy
   );
endinterface

// File: rtl/neuron_ofifo.sv
// neuron_ofifo: 2-entry first-word-fall-through FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module neuron_ofifo import neuron_accum_pkg::*; #(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic         full,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty
);
   logic [W-1:0] mem [2];
   logic wp, rp;
   logic [1:0] cnt;
   logic do_push, do_pop;
   assign empty = cnt == 2'd0;
   assign full = cnt == 2'd2;
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = empty ? '0 : mem[rp];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem <= '{default: '0};
         wp <= 1'b0;
         rp <= 1'b0;
         cnt <= 2'd0;
      end else begin
         if (do_push) mem[wp] <= din;
         wp <= wp ^ do_push;
         rp <= rp ^ do_pop;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/neuron_accum.sv
// neuron_accum: accumulates a neuron's partial sums plus bias, shifts, saturates and activates into an output FIFO.
// NEURON_LEAKY_RELU_EN selects leaky ReLU (negative >>> 3) instead of plain ReLU.
module neuron_accum import neuron_accum_pkg::*; (
   input logic clk,
   input logic rst,
   neuron_accum_if.slave bus
);
   state_t state, nxt;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [4:0] shift;
   logic ovf_r;
   logic xfer, close, full, empty, push_ok, hi, lo;
   logic signed [DATA_W-1:0] sat_v, act_v;
   assign bus.in_ready = state == IDLE || state == ACC;
   assign xfer = bus.in_valid && bus.in_ready;
   assign close = bus.in_last || (state == IDLE ? N_IN == 1 : cnt == CNT_W'(N_IN - 1));
   assign push_ok = state == ACT && (!full || (bus.out_ready && !empty));
   assign hi = acc > SAT_MAX;
   assign lo = acc < SAT_MIN;
   assign sat_v = hi ? SAT_MAX[DATA_W-1:0] : lo ? SAT_MIN[DATA_W-1:0] : acc[DATA_W-1:0];
`ifdef NEURON_LEAKY_RELU_EN
   assign act_v = sat_v[DATA_W-1] ? sat_v >>> LEAKY_SHIFT : sat_v;
`else
   assign act_v = sat_v[DATA_W-1] ? '0 : sat_v;
`endif
   assign bus.out_valid = !empty;
   assign bus.busy = state != IDLE || !empty;
   assign bus.ovf = ovf_r;
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, ACC: nxt = xfer ? (close ? BIAS : ACC) : state;
         BIAS: nxt = ACT;
         default: nxt = push_ok ? IDLE : ACT;
      endcase
   end
   // acc is reused to hold the shifted result between BIAS and ACT
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         acc <= '0;
         cnt <= '0;
         shift <= '0;
         ovf_r <= 1'b0;
      end else begin
         state <= nxt;
         if (xfer) begin
            acc <= state == IDLE ? sext(bus.in_data) + sext(bus.bias) : acc + sext(bus.in_data);
            cnt <= state == IDLE ? CNT_W'(1) : cnt + 1'b1;
            if (state == IDLE) shift <= bus.cfg_shift;
         end else if (state == BIAS) begin
            acc <= acc >>> shift;
         end
         ovf_r <= (push_ok && (hi || lo)) ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf_r;
      end
   end
   neuron_ofifo #(.W(DATA_W)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(state == ACT),
      .din(act_v),
      .full(full),
      .pop(bus.out_ready),
      .dout(bus.out_data),
      .empty(empty)
   );
endmodule

// File: tb/tb_neuron_accum.sv
// tb_neuron_accum: directed scenarios for neuron_accum with hand-computed expectations.
module tb_neuron_accum;
   import neuron_accum_pkg::*;
   typedef logic signed [DATA_W-1:0] d_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   d_t v;
   neuron_accum_if bus();
   neuron_accum dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic idle_in();
      bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.bias = 0;
      bus.cfg_shift = 0; bus.out_ready = 0; bus.ovf_clr = 0;
   endtask

   task automatic send(input d_t d, input bit last, input d_t b, input logic [4:0] s);
      bus.in_valid = 1; bus.in_data = d; bus.in_last = last; bus.bias = b; bus.cfg_shift = s;
      for (int i = 0; i < 40 && bus.in_ready !== 1'b1; i++) @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL send_timeout: in_ready=%b want 1", bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 0; bus.in_last = 0;
   endtask

   task automatic get_out(output d_t r);
      for (int i = 0; i < 40 && bus.out_valid !== 1'b1; i++) @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL pop_timeout: out_valid=%b want 1", bus.out_valid); end
      r = bus.out_data;
      bus.out_ready = 1;
      @(negedge clk);
      bus.out_ready = 0;
   endtask

   task automatic test_reset();
      idle_in();
      #1 rst = 0;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
      n_cmp++; if (bus.out_data !== 16'sd0) begin n_err++; $display("FAIL rst_out_data: got %0d want 0", bus.out_data); end
      rst = 1;
      @(negedge clk);
   endtask

   task automatic test_single();
      bus.out_ready = 1;
      send(5, 0, 1, 0);
      send(-2, 0, 0, 0);
      send(10, 1, 0, 0);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_t1: out_valid=%b want 0", bus.out_valid); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_bias: got %b want 1", bus.busy); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_t2: out_valid=%b want 0", bus.out_valid); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL lat_t3: out_valid=%b want 1", bus.out_valid); end
      n_cmp++; if (bus.out_data !== 16'sd14) begin n_err++; $display("FAIL single_data: got %0d want 14", bus.out_data); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL single_ovf: got %b want 0", bus.ovf); end
      @(negedge clk);
      bus.out_ready = 0;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drained: out_valid=%b want 0", bus.out_valid); end
   endtask

   task automatic test_activation();
      d_t e;
`ifdef NEURON_LEAKY_RELU_EN
      e = -2;
`else
      e = 0;
`endif
      send(-20, 0, 0, 0);
      send(4, 1, 0, 0);
      get_out(v);
      n_cmp++; if (v !== e) begin n_err++; $display("FAIL act_neg: got %0d want %0d", v, e); end
   endtask

   task automatic test_shift();
      d_t e;
`ifdef NEURON_LEAKY_RELU_EN
      e = -1;
`else
      e = 0;
`endif
      send(1000, 1, 24, 4);
      get_out(v);
      n_cmp++; if (v !== 16'sd64) begin n_err++; $display("FAIL shift_pos: got %0d want 64", v); end
      send(-17, 1, 0, 2);
      get_out(v);
      n_cmp++; if (v !== e) begin n_err++; $display("FAIL shift_neg: got %0d want %0d", v, e); end
   endtask

   task automatic test_saturation();
      d_t e;
`ifdef NEURON_LEAKY_RELU_EN
      e = -4096;
`else
      e = 0;
`endif
      for (int i = 0; i < 8; i++) send(32767, 0, 0, 0);
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL forced_close: in_ready=%b want 0", bus.in_ready); end
      get_out(v);
      n_cmp++; if (v !== 16'sd32767) begin n_err++; $display("FAIL sat_data: got %0d want 32767", v); end
      n_cmp++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %b want 1", bus.ovf); end
      bus.ovf_clr = 1;
      @(negedge clk);
      bus.ovf_clr = 0;
      n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", bus.ovf); end
      send(32767, 1, 32767, 0);
      @(negedge clk);
      bus.ovf_clr = 1;
      @(negedge clk);
      bus.ovf_clr = 0;
      n_cmp++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", bus.ovf); end
      get_out(v);
      n_cmp++; if (v !== 16'sd32767) begin n_err++; $display("FAIL sat2_data: got %0d want 32767", v); end
      send(-32768, 1, -32768, 0);
      get_out(v);
      n_cmp++; if (v !== e) begin n_err++; $display("FAIL sat_neg: got %0d want %0d", v, e); end
      bus.ovf_clr = 1;
      @(negedge clk);
      bus.ovf_clr = 0;
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 0;
      send(1, 1, 0, 0);
      send(2, 1, 0, 0);
      send(3, 1, 0, 0);
      repeat (4) @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall: in_ready=%b want 0", bus.in_ready); end
      n_cmp++; if (bus.out_data !== 16'sd1) begin n_err++; $display("FAIL bp_head: got %0d want 1", bus.out_data); end
      for (int i = 1; i <= 3; i++) begin
         get_out(v);
         n_cmp++; if (v !== d_t'(i)) begin n_err++; $display("FAIL bp_order%0d: got %0d want %0d", i, v, i); end
      end
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: out_valid=%b want 0", bus.out_valid); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_async_reset();
      bus.out_ready = 0;
      send(9, 1, 0, 0);
      repeat (3) @(negedge clk);
      send(4, 0, 0, 0);
      send(5, 0, 0, 0);
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_pre_reset: got %b want 1", bus.busy); end
      #2 rst = 0;
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      send(7, 1, 0, 0);
      get_out(v);
      n_cmp++; if (v !== 16'sd7) begin n_err++; $display("FAIL arst_next: got %0d want 7", v); end
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL arst_residue: out_valid=%b want 0", bus.out_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_activation();
      test_shift();
      test_saturation();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
